fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning instruction buffer entries (power of two, 2..8).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 SHALL have port clk  in  1  the single clock, all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous active-low reset (0 = reset).
REQ-006 SHALL have port redirect  in  1  one-cycle pulse that loads a new fetch address.
REQ-007 SHALL have port redirect_pc  in  32  new fetch address, sampled when redirect=1.
REQ-008 SHALL have port mem_req  out  1  word-read request to memory.
REQ-009 SHALL have port mem_addr  out  32  read address, valid while mem_req=1.
REQ-010 SHALL have port mem_ack  in  1  read complete; mem_rdata and mem_fault valid this cycle.
REQ-011 SHALL have port mem_rdata  in  32  read data.
REQ-012 SHALL have port mem_fault  in  1  read faulted.
REQ-013 SHALL have port inst_valid  out  1  buffer head holds an instruction.
REQ-014 SHALL have port inst_ready  in  1  decode accepts the head this cycle.
REQ-015 SHALL have port inst_data  out  32  head instruction word.
REQ-016 SHALL have port inst_pc  out  32  head instruction address.
REQ-017 SHALL have port inst_fault  out  1  head entry is a fault marker, not an instruction.

Function
REQ-018 SHALL run an FSM with states IDLE (no request), BUSY (request outstanding, result kept), and DRAIN (request outstanding, result discarded).
REQ-019 SHALL, in BUSY and DRAIN, hold mem_req=1 and mem_addr stable until the cycle mem_ack=1; mem_ack outside a request is ignored.
REQ-020 SHALL, on ack in BUSY, push {fetch_pc, mem_rdata, mem_fault} and advance fetch_pc by 4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-021 SHALL issue a new request (IDLE->BUSY, or BUSY->BUSY on the ack cycle) only if occupancy after this cycle's push/pop plus the new request fits in DEPTH, and only while not halted.
REQ-022 SHALL present the head entry with inst_valid=1 the cycle after its ack (latency: one cycle from ack to inst_valid).
REQ-023 SHALL pop the head when inst_valid & inst_ready; push and pop in the same cycle keep occupancy unchanged.
REQ-024 SHALL set halted after pushing a faulted entry and stop requesting until redirect.
REQ-025 SHALL, on redirect with redirect_pc[1:0]!=0, clear the buffer, push one fault entry {redirect_pc, 0, 1} on the next cycle, and set halted.
REQ-026 SHALL, on redirect, clear the buffer (inst_valid=0 next cycle), set fetch_pc=redirect_pc, and clear halted; from BUSY it goes to DRAIN, from IDLE it goes to BUSY next cycle.
REQ-027 SHALL, in DRAIN, discard the ack data and then request fetch_pc (DRAIN->BUSY on the ack cycle).
REQ-028 SHALL, on a further redirect during DRAIN, update fetch_pc and remain in DRAIN.
REQ-029 SHALL give redirect priority over a same-cycle pop and push; the popped and acked data are both discarded.

Reset
REQ-030 SHALL, while reset=0, force state=IDLE, fetch_pc=RESET_PC, occupancy 0, halted=0, mem_req=0, inst_valid=0, inst_fault=0, inst_data=0, inst_pc=0.
REQ-031 SHALL drive mem_req=1 with mem_addr=RESET_PC in the first cycle after reset deasserts.
REQ-032 SHALL, on reset during BUSY or DRAIN, drop mem_req immediately; a later stray ack is ignored.

Structure
REQ-033 SHALL take the FSM state encoding and the entry width constant (65 bits: pc, data, fault) from the shared core package.
REQ-034 SHALL place the storage in one sub-module, fetch_fifo (DEPTH-entry synchronous FIFO with push, pop, and clear inputs).

Verification
REQ-035 SHALL cover: reset release, ack every 3 cycles, inst_ready=1 -> addresses 0,4,8 issued and inst_pc 0,4,8 each one cycle after its ack.
REQ-036 SHALL cover: inst_ready=0, DEPTH=2, ack in 1 cycle -> exactly 2 requests, mem_req=0 while full; one pop -> exactly one further request.
REQ-037 SHALL cover: redirect to 32'h100 with a request to 32'h8 outstanding -> DRAIN, ack data for 32'h8 never appears, next mem_addr=32'h100.
REQ-038 SHALL cover: mem_fault=1 on ack for 32'h10 -> entry inst_fault=1, inst_pc=32'h10, no requests until redirect to 32'h40, then fetch resumes at 32'h40.
REQ-039 SHALL cover: redirect to 32'h102 -> no request, one entry inst_fault=1 with inst_pc=32'h102.
REQ-040 SHALL cover: redirect to 32'hFFFF_FFFC -> requests 32'hFFFF_FFFC then 32'h0000_0000.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared fetch constants: FSM state encoding, instruction
//               buffer entry layout and an entry-packing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    localparam int c_PC_W    = 32;
    localparam int c_DATA_W  = 32;
    localparam int c_ENTRY_W = c_PC_W + c_DATA_W + 1;   // pc, data, fault

    // Fetch FSM state encoding
    localparam logic [1:0] c_ST_IDLE  = 2'd0;  // no request outstanding
    localparam logic [1:0] c_ST_BUSY  = 2'd1;  // request outstanding, result kept
    localparam logic [1:0] c_ST_DRAIN = 2'd2;  // request outstanding, result discarded

    typedef struct packed {
        logic [c_PC_W-1:0]   pc;
        logic [c_DATA_W-1:0] data;
        logic                fault;
    } fetch_entry_t;

    function automatic fetch_entry_t make_entry(input logic [c_PC_W-1:0]   pc,
                                                input logic [c_DATA_W-1:0] data,
                                                input logic                fault);
        fetch_entry_t e;
        e.pc    = pc;
        e.data  = data;
        e.fault = fault;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : DEPTH-entry synchronous FIFO holding fetched entries, with
//               push, pop and a clear that empties it in one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_push,
    input  logic [c_ENTRY_W-1:0]        i_push_data,
    input  logic                        i_pop,
    input  logic                        i_clear,
    output logic [$clog2(DEPTH):0]      o_count,
    output logic [c_ENTRY_W-1:0]        o_head
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [c_ENTRY_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    // Overflow/underflow guards keep the pointers coherent even if misused
    assign w_do_push = i_push & (r_count != c_FULL);
    assign w_do_pop  = i_pop  & (r_count != '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];

    // Pointer and occupancy tracking; clear wins over push/pop
    always_ff @(posedge clk) begin
        if (!reset || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{(c_CNT_W-1){1'b0}}, w_do_push}
                               - {{(c_CNT_W-1){1'b0}}, w_do_pop};
        end
    end

    // Entry storage; contents are only meaningful while counted valid
    always_ff @(posedge clk) begin
        if (w_do_push && reset && !i_clear) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch front end. Issues sequential word reads,
//               buffers results for decode, handles redirects (draining the
//               in-flight read) and halts on fetch faults.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        mem_fault,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        inst_fault
);

    localparam int c_CNT_W = $clog2(DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    logic [1:0]         r_state;
    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_req_addr;    // held separately so a redirect in DRAIN cannot disturb mem_addr
    logic [31:0]        r_fault_pc;
    logic               r_halted;
    logic               r_fault_pend;  // misaligned redirect: push its fault entry this cycle

    logic [c_CNT_W-1:0] w_count;
    logic [c_CNT_W-1:0] w_occ_after;
    fetch_entry_t       w_head;
    fetch_entry_t       w_push_entry;
    logic               w_outstanding;
    logic               w_ack;
    logic               w_push_ack;
    logic               w_push_fault;
    logic               w_push;
    logic               w_pop;
    logic               w_misaligned;
    logic               w_free;
    logic               w_halt_next;
    logic               w_can_issue;
    logic [31:0]        w_next_pc;

    assign w_outstanding = (r_state != c_ST_IDLE);
    assign mem_req       = reset & w_outstanding;   // drops as soon as reset asserts
    assign mem_addr      = r_req_addr;

    assign inst_valid    = reset & (w_count != '0);
    assign inst_data     = inst_valid ? w_head.data : 32'h0;
    assign inst_pc       = inst_valid ? w_head.pc   : 32'h0;
    assign inst_fault    = inst_valid & w_head.fault;

    // Redirect overrides any same-cycle pop or push
    assign w_ack         = mem_ack & w_outstanding;
    assign w_push_ack    = w_ack & (r_state == c_ST_BUSY) & ~redirect;
    assign w_push_fault  = r_fault_pend & ~redirect;
    assign w_push        = w_push_ack | w_push_fault;
    assign w_pop         = inst_valid & inst_ready & ~redirect;
    assign w_misaligned  = (redirect_pc[1:0] != 2'b00);
    assign w_push_entry  = w_push_fault ? make_entry(r_fault_pc, 32'h0, 1'b1)
                                        : make_entry(r_req_addr, mem_rdata, mem_fault);

    // Next-cycle occupancy, halt state and fetch address drive the issue decision
    always_comb begin
        w_occ_after = '0;
        if (!redirect) begin
            w_occ_after = w_count + {{(c_CNT_W-1){1'b0}}, w_push}
                                  - {{(c_CNT_W-1){1'b0}}, w_pop};
        end
        w_halt_next = redirect ? w_misaligned : (r_halted | (w_push_ack & mem_fault));
        w_can_issue = (w_occ_after < c_DEPTH_CNT) & ~w_halt_next;
        w_next_pc   = redirect   ? redirect_pc :
                      w_push_ack ? r_fetch_pc + 32'd4 : r_fetch_pc;
        w_free      = ~w_outstanding | w_ack;
    end

    // Fetch FSM: a request ends only on ack; a redirect mid-request drains it
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= c_ST_IDLE;
            r_fetch_pc   <= RESET_PC;
            r_req_addr   <= RESET_PC;
            r_fault_pc   <= 32'h0;
            r_halted     <= 1'b0;
            r_fault_pend <= 1'b0;
        end else begin
            r_fetch_pc   <= w_next_pc;
            r_halted     <= w_halt_next;
            r_fault_pend <= redirect & w_misaligned;
            if (redirect) r_fault_pc <= redirect_pc;
            if (w_free) begin
                if (w_can_issue) begin
                    r_state    <= c_ST_BUSY;
                    r_req_addr <= w_next_pc;
                end else begin
                    r_state    <= c_ST_IDLE;
                end
            end else if (redirect) begin
                r_state <= c_ST_DRAIN;
            end
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .i_clear     (redirect),
        .o_count     (w_count),
        .o_head      (w_head)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit (DEPTH=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_fault = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_fault;

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .DEPTH(2),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mem_fault(mem_fault), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
        .inst_fault(inst_fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT one edge past reset release: request to address 0 on the bus
    task automatic do_reset();
        reset = 1'b0; redirect = 1'b0; mem_ack = 1'b0; mem_fault = 1'b0; inst_ready = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        checks++;
        if ({mem_req, inst_valid, inst_fault, inst_data, inst_pc} !== 67'b0) begin
            errors++;
            $display("FAIL reset_outputs got req=%b v=%b f=%b d=%h pc=%h exp all zero",
                     mem_req, inst_valid, inst_fault, inst_data, inst_pc);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL reset_first_req got %b/%h exp 1/00000000", mem_req, mem_addr);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        inst_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({mem_req, mem_addr} !== {1'b1, 32'(4*k)}) begin
                errors++;
                $display("FAIL seq_req1 k=%0d got %b/%h exp 1/%h", k, mem_req, mem_addr, 32'(4*k));
            end
            tick();
            checks++;
            if ({mem_req, mem_addr} !== {1'b1, 32'(4*k)}) begin
                errors++;
                $display("FAIL seq_req2 k=%0d got %b/%h exp 1/%h", k, mem_req, mem_addr, 32'(4*k));
            end
            tick();
            mem_ack = 1'b1; mem_rdata = 32'hA000_0000 | 32'(k);
            checks++;
            if (inst_valid !== 1'b0) begin
                errors++;
                $display("FAIL seq_early_valid k=%0d got %b exp 0", k, inst_valid);
            end
            tick();
            mem_ack = 1'b0;
            checks++;
            if ({inst_valid, inst_pc, inst_data} !== {1'b1, 32'(4*k), 32'hA000_0000 | 32'(k)}) begin
                errors++;
                $display("FAIL seq_inst k=%0d got %b/%h/%h exp 1/%h/%h", k, inst_valid, inst_pc,
                         inst_data, 32'(4*k), 32'hA000_0000 | 32'(k));
            end
        end
        // Reset with a request to 12 outstanding drops mem_req without a clock edge
        reset = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_drop_req got %b exp 0", mem_req);
        end
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_stray_ack got valid=%b exp 0", inst_valid);
        end
        reset = 1'b1;
        inst_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        mem_ack = 1'b1; mem_rdata = 32'hB000_0000;
        tick();
        checks++;
        if ({mem_req, mem_addr, inst_valid, inst_pc} !== {1'b1, 32'h4, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL bp_second_req got %b/%h v=%b pc=%h exp 1/4 v=1 pc=0",
                     mem_req, mem_addr, inst_valid, inst_pc);
        end
        mem_rdata = 32'hB000_0004;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL bp_full_stop got %b exp 0", mem_req);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (mem_req !== 1'b0) begin
                errors++;
                $display("FAIL bp_full_hold i=%0d got %b exp 0", i, mem_req);
            end
        end
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0;
        tick();
        checks++;
        if ({mem_req, inst_valid, inst_pc, inst_data} !== {1'b0, 1'b1, 32'h0, 32'hB000_0000}) begin
            errors++;
            $display("FAIL bp_idle_stray_ack got req=%b %b/%h/%h exp 0 1/0/b0000000",
                     mem_req, inst_valid, inst_pc, inst_data);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        checks++;
        if ({inst_valid, inst_pc, mem_req, mem_addr} !== {1'b1, 32'h4, 1'b1, 32'h8}) begin
            errors++;
            $display("FAIL bp_pop_refill got %b/%h req %b/%h exp 1/4 req 1/8",
                     inst_valid, inst_pc, mem_req, mem_addr);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL bp_refull got %b exp 0", mem_req);
        end
        tick();
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL bp_one_more_only got %b exp 0", mem_req);
        end
    endtask

    task automatic test_redirect_drain();
        do_reset();
        inst_ready = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hC000_0000;
        tick();
        mem_rdata = 32'hC000_0004;
        tick();
        mem_ack = 1'b0;
        checks++;
        if ({inst_valid, inst_pc, mem_req, mem_addr} !== {1'b1, 32'h4, 1'b1, 32'h8}) begin
            errors++;
            $display("FAIL drain_setup got %b/%h req %b/%h exp 1/4 req 1/8",
                     inst_valid, inst_pc, mem_req, mem_addr);
        end
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        checks++;
        if ({inst_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h8}) begin
            errors++;
            $display("FAIL drain_hold got v=%b req %b/%h exp v=0 req 1/8", inst_valid, mem_req, mem_addr);
        end
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_0008;
        tick();
        mem_ack = 1'b0;
        checks++;
        if ({inst_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h100}) begin
            errors++;
            $display("FAIL drain_discard got v=%b req %b/%h exp v=0 req 1/100", inst_valid, mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h1111_0100;
        tick();
        mem_ack = 1'b0;
        checks++;
        if ({inst_valid, inst_pc, inst_data} !== {1'b1, 32'h100, 32'h1111_0100}) begin
            errors++;
            $display("FAIL drain_resume got %b/%h/%h exp 1/100/11110100", inst_valid, inst_pc, inst_data);
        end
        // Second redirect while already draining keeps the original address on the bus
        redirect = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_pc = 32'h300;
        tick();
        redirect = 1'b0;
        checks++;
        if ({inst_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h104}) begin
            errors++;
            $display("FAIL drain_rerdr got v=%b req %b/%h exp v=0 req 1/104", inst_valid, mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_0104;
        tick();
        mem_ack = 1'b0;
        checks++;
        if ({inst_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h300}) begin
            errors++;
            $display("FAIL drain_last_pc got v=%b req %b/%h exp v=0 req 1/300", inst_valid, mem_req, mem_addr);
        end
        inst_ready = 1'b0;
    endtask

    task automatic test_redirect_priority();
        do_reset();
        inst_ready = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hD000_0000;
        tick();
        redirect = 1'b1; redirect_pc = 32'h80; mem_rdata = 32'hD000_0004;
        tick();
        redirect = 1'b0; mem_ack = 1'b0;
        checks++;
        if ({inst_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h80}) begin
            errors++;
            $display("FAIL prio_redirect got v=%b req %b/%h exp v=0 req 1/80", inst_valid, mem_req, mem_addr);
        end
        tick();
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL prio_no_stale got v=%b pc=%h exp v=0", inst_valid, inst_pc);
        end
        inst_ready = 1'b0;
    endtask

    task automatic test_fault();
        do_reset();
        inst_ready = 1'b1;
        mem_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mem_rdata = 32'hF000_0000 | 32'(k);
            tick();
        end
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h10}) begin
            errors++;
            $display("FAIL fault_setup got %b/%h exp 1/10", mem_req, mem_addr);
        end
        mem_fault = 1'b1; mem_rdata = 32'h0000_EEEE;
        tick();
        mem_ack = 1'b0; mem_fault = 1'b0; inst_ready = 1'b0;
        checks++;
        if ({inst_valid, inst_fault, inst_pc, mem_req} !== {1'b1, 1'b1, 32'h10, 1'b0}) begin
            errors++;
            $display("FAIL fault_entry got v=%b f=%b pc=%h req=%b exp 1/1/10/0",
                     inst_valid, inst_fault, inst_pc, mem_req);
        end
        inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({mem_req, inst_valid} !== 2'b00) begin
                errors++;
                $display("FAIL fault_halted i=%0d got req=%b v=%b exp 0/0", i, mem_req, inst_valid);
            end
        end
        redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h40}) begin
            errors++;
            $display("FAIL fault_resume got %b/%h exp 1/40", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h4040_4040;
        tick();
        mem_ack = 1'b0;
        checks++;
        if ({inst_valid, inst_fault, inst_pc, mem_addr} !== {1'b1, 1'b0, 32'h40, 32'h44}) begin
            errors++;
            $display("FAIL fault_after got v=%b f=%b pc=%h addr=%h exp 1/0/40/44",
                     inst_valid, inst_fault, inst_pc, mem_addr);
        end
        inst_ready = 1'b0;
    endtask

    task automatic test_misaligned();
        do_reset();
        redirect = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect = 1'b0;
        checks++;
        if ({inst_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL mis_drain got v=%b req %b/%h exp v=0 req 1/0", inst_valid, mem_req, mem_addr);
        end
        tick();
        checks++;
        if ({inst_valid, inst_fault, inst_pc} !== {1'b1, 1'b1, 32'h102}) begin
            errors++;
            $display("FAIL mis_entry got v=%b f=%b pc=%h exp 1/1/102", inst_valid, inst_fault, inst_pc);
        end
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_0000;
        tick();
        mem_ack = 1'b0;
        tick();
        checks++;
        if ({mem_req, inst_valid, inst_fault, inst_pc} !== {1'b0, 1'b1, 1'b1, 32'h102}) begin
            errors++;
            $display("FAIL mis_no_req got req=%b v=%b f=%b pc=%h exp 0/1/1/102",
                     mem_req, inst_valid, inst_fault, inst_pc);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        checks++;
        if ({mem_req, inst_valid} !== 2'b00) begin
            errors++;
            $display("FAIL mis_single got req=%b v=%b exp 0/0", mem_req, inst_valid);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_0000;
        tick();
        mem_ack = 1'b0;
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            errors++;
            $display("FAIL wrap_first got %b/%h exp 1/fffffffc", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h5A5A_5A5A; inst_ready = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++;
        if ({inst_valid, inst_pc, mem_req, mem_addr} !== {1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL wrap_next got %b/%h req %b/%h exp 1/fffffffc req 1/0",
                     inst_valid, inst_pc, mem_req, mem_addr);
        end
        inst_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_drain();
        test_redirect_priority();
        test_fault();
        test_misaligned();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
